// File: rtl/g_4and2_qual.sv
// -----------------------------------------------------------------------------
// g_4and2_qual
//
// Registered qualifier stage for the four-input AND term
//    Y = ~AN & ~BN & C & D
// The operands are registered first, and the term is evaluated from those
// registered copies. Q asserts only after the term has been true for QUAL_CYC
// consecutive enabled cycles. Q releases only after the term has been false for
// QUAL_CYC consecutive enabled cycles. A one-cycle pulse QP marks each qualified
// rise of Q, and EVT counts these rises (the counter wraps).
//
// Build option:
//    G_4AND2_QUAL_SYNC_EN - when defined, each operand first passes through a
//                           2-flop synchronizer ahead of the input register.
//                           This adds two cycles of latency.
//
// Parameters:
//    QUAL_CYC - consecutive enabled cycles needed to assert or release Q
//               (legal range 1..2**CNT_W)
//    CNT_W    - width of the qualification counter
//    EVT_W    - width of the EVT event counter
//
// Ports:
//    CK   in   clock, rising edge
//    CDN  in   asynchronous active-low clear
//    EN   in   enable for the FSM, the counters and QP
//    CLR  in   synchronous clear of EVT (independent of EN, wins over increment)
//    AN   in   active-low AND operand
//    BN   in   active-low AND operand
//    C    in   active-high AND operand
//    D    in   active-high AND operand
//    Q    out  qualified AND level, registered
//    QP   out  one-cycle pulse on a qualified rise of Q, registered
//    EVT  out  count of qualified rises, EVT_W bits, wraps
// -----------------------------------------------------------------------------
module g_4and2_qual #(
   parameter int QUAL_CYC = 4,
   parameter int CNT_W    = 3,
   parameter int EVT_W    = 8
) (
   input  logic             CK,
   input  logic             CDN,
   input  logic             EN,
   input  logic             CLR,
   input  logic             AN,
   input  logic             BN,
   input  logic             C,
   input  logic             D,
   output logic             Q,
   output logic             QP,
   output logic [EVT_W-1:0] EVT
);

   // Reject an unreachable qualification length at elaboration time.
   generate
      if (QUAL_CYC < 1 || QUAL_CYC > (1 << CNT_W)) begin : g_bad_qual_cyc
         $error("g_4and2_qual: QUAL_CYC must be within 1..2**CNT_W");
      end
   endgenerate

   // The count reaches this value on the cycle before the state flips.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QUAL_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      QUAL   = 2'd1,
      ACTIVE = 2'd2,
      DROP   = 2'd3
   } state_t;

   // ---------------------------------------------------------------- inputs
   // Bit order throughout the input stage: {AN, BN, C, D}.
   logic [3:0] raw_in;
   logic [3:0] stage_in;
   logic [3:0] in_reg;

   assign raw_in = {AN, BN, C, D};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_in_bit
`ifdef G_4AND2_QUAL_SYNC_EN
         logic sync1_reg;
         logic sync2_reg;

         always_ff @(posedge CK or negedge CDN) begin
            if (!CDN) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
            end else begin
               sync1_reg <= raw_in[gi];
               sync2_reg <= sync1_reg;
            end
         end

         assign stage_in[gi] = sync2_reg;
`else
         assign stage_in[gi] = raw_in[gi];
`endif

         // Capture happens on every edge, whatever the value of EN. This way
         // the term always reflects fresh operands when counting resumes.
         always_ff @(posedge CK or negedge CDN) begin
            if (!CDN) begin
               in_reg[gi] <= 1'b0;
            end else begin
               in_reg[gi] <= stage_in[gi];
            end
         end
      end
   endgenerate

   logic term;
   assign term = ~in_reg[3] & ~in_reg[2] & in_reg[1] & in_reg[0];

   // ------------------------------------------------------------------- FSM
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             rise_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rise_next  = 1'b0;
      if (EN) begin
         case (state_reg)
            IDLE: begin
               if (term) begin
                  if (QUAL_CYC == 1) begin
                     state_next = ACTIVE;
                     cnt_next   = '0;
                     rise_next  = 1'b1;
                  end else begin
                     state_next = QUAL;
                     cnt_next   = CNT_W'(1);
                  end
               end
            end
            QUAL: begin
               if (!term) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt_reg == LAST_CNT) begin
                  state_next = ACTIVE;
                  cnt_next   = '0;
                  rise_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            ACTIVE: begin
               if (!term) begin
                  if (QUAL_CYC == 1) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else begin
                     state_next = DROP;
                     cnt_next   = CNT_W'(1);
                  end
               end
            end
            DROP: begin
               // A recovery to ACTIVE is not a new event, so no pulse here.
               if (term) begin
                  state_next = ACTIVE;
                  cnt_next   = '0;
               end else if (cnt_reg == LAST_CNT) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   logic             q_reg;
   logic             qp_reg;
   logic [EVT_W-1:0] evt_reg;

   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         q_reg     <= 1'b0;
         qp_reg    <= 1'b0;
         evt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         q_reg     <= (state_next == ACTIVE) || (state_next == DROP);
         // rise_next is already gated by EN, so QP stays low while disabled.
         qp_reg    <= rise_next;
         if (CLR) begin
            evt_reg <= '0;
         end else if (rise_next) begin
            evt_reg <= evt_reg + EVT_W'(1);
         end
      end
   end

   assign Q   = q_reg;
   assign QP  = qp_reg;
   assign EVT = evt_reg;

endmodule

// File: tb/tb_g_4and2_qual.sv
// -----------------------------------------------------------------------------
// tb_g_4and2_qual
//
// Self-checking bench for g_4and2_qual. Each driven cycle advances a small
// reference model. The model tracks the run of consecutive enabled cycles in
// which the term disagrees with Q. The expected {Q, QP, EVT} is pushed to a
// scoreboard queue, and the entry is popped and compared one time unit after
// the clock edge.
// -----------------------------------------------------------------------------
module tb_g_4and2_qual;

   localparam int QUAL_CYC = 4;
   localparam int CNT_W    = 3;
   localparam int EVT_W    = 2;
`ifdef G_4AND2_QUAL_SYNC_EN
   localparam int DEPTH = 3;
`else
   localparam int DEPTH = 1;
`endif

   logic CK = 1'b0;
   logic CDN, EN, CLR, AN, BN, C, D;
   logic Q, QP;
   logic [EVT_W-1:0] EVT;

   g_4and2_qual #(
      .QUAL_CYC(QUAL_CYC),
      .CNT_W   (CNT_W),
      .EVT_W   (EVT_W)
   ) dut (
      .CK (CK),
      .CDN(CDN),
      .EN (EN),
      .CLR(CLR),
      .AN (AN),
      .BN (BN),
      .C  (C),
      .D  (D),
      .Q  (Q),
      .QP (QP),
      .EVT(EVT)
   );

   always #5 CK = ~CK;

   typedef struct packed {
      logic             q;
      logic             qp;
      logic [EVT_W-1:0] evt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   bit               m_pipe[DEPTH];
   bit               m_q;
   bit               m_qp;
   int               m_run;
   logic [EVT_W-1:0] m_evt;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_pipe[i] = 1'b0;
      m_q   = 1'b0;
      m_qp  = 1'b0;
      m_run = 0;
      m_evt = '0;
   endtask

   // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
   task automatic step(input string tag, input bit en, input bit clr,
                       input bit an, input bit bn, input bit c, input bit d);
      bit   t_used;
      bit   rise;
      exp_t e;
      EN  = en;
      CLR = clr;
      AN  = an;
      BN  = bn;
      C   = c;
      D   = d;
      t_used = m_pipe[DEPTH-1];
      for (int i = DEPTH - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = ~an & ~bn & c & d;
      rise = 1'b0;
      if (en) begin
         if (t_used != m_q) begin
            m_run++;
            if (m_run == QUAL_CYC) begin
               m_q   = ~m_q;
               m_run = 0;
               rise  = m_q;
            end
         end else begin
            m_run = 0;
         end
      end
      m_qp = rise;
      if (clr) m_evt = '0;
      else if (rise) m_evt = m_evt + 1'b1;
      sb_q.push_back('{q: m_q, qp: m_qp, evt: m_evt});

      @(posedge CK);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, ".sb_empty"}, 8'd0, 8'd1);
      end else begin
         e = sb_q.pop_front();
         $display("t=%0t %s en=%0b clr=%0b in=%0b%0b%0b%0b Q=%0b QP=%0b EVT=%0d",
                  $time, tag, en, clr, an, bn, c, d, Q, QP, EVT);
         check_val({tag, ".Q"},   {7'd0, Q},   {7'd0, e.q});
         check_val({tag, ".QP"},  {7'd0, QP},  {7'd0, e.qp});
         check_val({tag, ".EVT"}, {6'd0, EVT}, {6'd0, e.evt});
      end
   endtask

   task automatic run(input string tag, input int n, input bit en, input bit clr,
                      input bit an, input bit bn, input bit c, input bit d);
      for (int k = 0; k < n; k++) step(tag, en, clr, an, bn, c, d);
   endtask

   // Term true: AN=0 BN=0 C=1 D=1
   task automatic on_cyc(input string tag, input int n);
      run(tag, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic off_cyc(input string tag, input int n);
      run(tag, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      CDN = 1'b0; EN = 1'b1; CLR = 1'b0;
      AN = 1'b0; BN = 1'b0; C = 1'b0; D = 1'b0;
      model_reset();
      repeat (2) @(posedge CK);
      #1;
      check_val("reset.Q",   {7'd0, Q},   {7'd0, m_q});
      check_val("reset.QP",  {7'd0, QP},  {7'd0, m_qp});
      check_val("reset.EVT", {6'd0, EVT}, {6'd0, m_evt});
      CDN = 1'b1;

      // Idle with the term false
      run("idle", 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Qualify, then release (EVT becomes 1)
      on_cyc("qualify", QUAL_CYC + DEPTH + 1);
      off_cyc("release", QUAL_CYC + DEPTH + 1);

      // Glitch: true for 3 cycles, then AN=1, then true long enough (EVT becomes 2)
      on_cyc("glitch", 3);
      run("glitch_an", 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      on_cyc("requal", QUAL_CYC + DEPTH + 1);

      // Hysteresis: a short drop holds Q, a full drop releases it
      off_cyc("hyst_short", 2);
      on_cyc("hyst_back", 4);
      off_cyc("hyst_long", QUAL_CYC + DEPTH + 1);

      // Two more rises take EVT through 3 and wrap it to 0
      for (int s = 0; s < 2; s++) begin
         on_cyc("wrap_on", QUAL_CYC + DEPTH + 1);
         off_cyc("wrap_off", QUAL_CYC + DEPTH + 1);
      end

      // EN=0 mid-qualification freezes the count
      on_cyc("en_pre", DEPTH + 2);
      run("en_off", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      on_cyc("en_resume", QUAL_CYC);
      off_cyc("en_release", QUAL_CYC + DEPTH + 1);

      // CLR on the same edge as the rise pulse
      on_cyc("clr_pre", QUAL_CYC + DEPTH - 1);
      run("clr_qp", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      on_cyc("clr_post", 2);
      off_cyc("clr_rel", QUAL_CYC + DEPTH + 1);

      // CLR while disabled still clears
      on_cyc("clr_en0_q", QUAL_CYC + DEPTH + 1);
      run("clr_en0", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      off_cyc("clr_en0_rel", QUAL_CYC + DEPTH + 1);

      // Random operand runs with occasional disable and clear
      begin
         bit want = 1'b0;
         for (int k = 0; k < 300; k++) begin
            bit en_r, clr_r, an_r, bn_r, c_r, d_r;
            if ($urandom_range(0, 5) == 0) want = ~want;
            en_r  = ($urandom_range(0, 9) != 0);
            clr_r = ($urandom_range(0, 29) == 0);
            if (want) begin
               an_r = 1'b0; bn_r = 1'b0; c_r = 1'b1; d_r = 1'b1;
            end else begin
               an_r = 1'($urandom_range(0, 1));
               bn_r = 1'($urandom_range(0, 1));
               c_r  = 1'($urandom_range(0, 1));
               d_r  = 1'($urandom_range(0, 1));
            end
            step("rand", en_r, clr_r, an_r, bn_r, c_r, d_r);
         end
      end
      off_cyc("rand_rel", QUAL_CYC + DEPTH + 1);

      // Asynchronous reset between edges, just after the rise pulse
      on_cyc("async_pre", QUAL_CYC + DEPTH);
      #2;
      CDN = 1'b0;
      #1;
      model_reset();
      check_val("async.Q",   {7'd0, Q},   {7'd0, m_q});
      check_val("async.QP",  {7'd0, QP},  {7'd0, m_qp});
      check_val("async.EVT", {6'd0, EVT}, {6'd0, m_evt});
      #1;
      CDN = 1'b1;
      off_cyc("post_rst", 6);
      on_cyc("post_rst_q", QUAL_CYC + DEPTH + 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
